ultrasonic_echo_emulator: RTL and testbench

//  Emulates the far end of the HC-SR04-style trigger/echo interface for on-board test of the

---
 rtl/ultrasonic_echo_emulator.sv | 152 +++++++++++++++
 tb/tb_ultrasonic_echo_emulator.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style sensor emulator: checks the controller's trigger pulse, waits the burst
// delay, then returns an echo pulse whose width is the programmed round-trip time in us.
module ultrasonic_echo_emulator #(
  parameter int TICK_DIV    = 50,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US    = 200,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 60000,
  parameter int ECHO_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trig,
  input  logic              enable,
  input  logic [ECHO_W-1:0] echo_us,
  output logic              echo,
  output logic              busy,
  output logic              done,
  output logic              trig_err
);

  localparam int US_MAX0  = (BURST_US > TIMEOUT_US) ? BURST_US : TIMEOUT_US;
  localparam int US_MAX   = (US_MAX0 > HOLDOFF_US) ? US_MAX0 : HOLDOFF_US;
  localparam int US_W     = $clog2(US_MAX + 1);
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TRIG_CYC = TRIG_MIN_US * TICK_DIV;
  localparam int TC_W     = $clog2(TRIG_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             trig_m;
  logic             trig_s;
  logic             trig_q;
  logic [PRE_W-1:0] pre;
  logic [US_W-1:0]  us_cnt;
  logic [US_W-1:0]  us_lim;
  logic [US_W-1:0]  w_lat;
  logic [TC_W-1:0]  tcnt;
  logic             timed;
  logic             tick;
  logic             us_done;
  logic             trig_long;
  logic             echo_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             trig_err_nxt;

  // Out-of-range or zero requests mean "no object": echo lasts the full timeout.
  function automatic logic [US_W-1:0] clamp_width(input logic [ECHO_W-1:0] req);
    logic [31:0] req_ext;
    req_ext = 32'(req);
    if (req_ext == 32'd0 || req_ext > 32'(TIMEOUT_US)) return US_W'(TIMEOUT_US);
    return US_W'(req_ext);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
      trig_q <= trig_s;
    end
  end

  assign timed     = state inside {S_BURST, S_ECHO, S_HOLDOFF};
  assign tick      = (pre == PRE_W'(TICK_DIV - 1));
  assign trig_long = (tcnt >= TC_W'(TRIG_CYC));

  always_comb begin
    us_lim = '0;
    case (state)
      S_BURST:   us_lim = US_W'(BURST_US);
      S_ECHO:    us_lim = w_lat;
      S_HOLDOFF: us_lim = US_W'(HOLDOFF_US);
      default:   us_lim = '0;
    endcase
  end

  assign us_done = timed && tick && (us_cnt == us_lim - US_W'(1));

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (trig_s && !trig_q) state_nxt = S_TRIG_HI;
        S_TRIG_HI: if (!trig_s) state_nxt = trig_long ? S_BURST : S_IDLE;
        S_BURST:   if (us_done) state_nxt = S_ECHO;
        S_ECHO:    if (us_done) state_nxt = S_HOLDOFF;
        S_HOLDOFF: if (us_done) state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    echo_nxt     = (state_nxt == S_ECHO);
    busy_nxt     = (state_nxt != S_IDLE);
    done_nxt     = enable && (state == S_ECHO) && us_done;
    trig_err_nxt = enable && (state == S_TRIG_HI) && !trig_s && !trig_long;
  end

  // Trigger width includes the edge-detect cycle, hence the preload of 1 while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      echo     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      trig_err <= 1'b0;
      pre      <= '0;
      us_cnt   <= '0;
      tcnt     <= '0;
    end else begin
      state    <= state_nxt;
      echo     <= echo_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      trig_err <= trig_err_nxt;
      if (state_nxt != state || !timed) begin
        pre    <= '0;
        us_cnt <= '0;
      end else if (tick) begin
        pre    <= '0;
        us_cnt <= us_cnt + US_W'(1);
      end else begin
        pre    <= pre + PRE_W'(1);
      end
      if (state == S_IDLE)
        tcnt <= TC_W'(1);
      else if (state == S_TRIG_HI && trig_s && !trig_long)
        tcnt <= tcnt + TC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_TRIG_HI && !trig_s) w_lat <= clamp_width(echo_us);
  end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Scoreboard bench for ultrasonic_echo_emulator: each test pushes the cycle-exact output
// events it expects and a negedge monitor pops and compares them as the DUT produces them.
module tb_ultrasonic_echo_emulator;

  localparam int TICK_DIV    = 4;
  localparam int TRIG_MIN_US = 3;
  localparam int BURST_US    = 5;
  localparam int TIMEOUT_US  = 40;
  localparam int HOLDOFF_US  = 10;
  localparam int ECHO_W      = 16;
  localparam int MIN_CYC     = TRIG_MIN_US * TICK_DIV;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              trig    = 1'b0;
  logic              enable  = 1'b1;
  logic [ECHO_W-1:0] echo_us = '0;
  logic              echo;
  logic              busy;
  logic              done;
  logic              trig_err;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef enum int {EV_BUSY_RISE, EV_TERR, EV_ECHO_RISE, EV_ECHO_FALL, EV_DONE, EV_BUSY_FALL} ev_t;
  typedef struct {
    ev_t kind;
    int  at;
  } exp_t;
  exp_t sb[$];

  ultrasonic_echo_emulator #(
    .TICK_DIV   (TICK_DIV),
    .TRIG_MIN_US(TRIG_MIN_US),
    .BURST_US   (BURST_US),
    .TIMEOUT_US (TIMEOUT_US),
    .HOLDOFF_US (HOLDOFF_US),
    .ECHO_W     (ECHO_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .trig    (trig),
    .enable  (enable),
    .echo_us (echo_us),
    .echo    (echo),
    .busy    (busy),
    .done    (done),
    .trig_err(trig_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_width(input int req);
    return (req == 0 || req > TIMEOUT_US) ? TIMEOUT_US : req;
  endfunction

  task automatic push(input ev_t k, input int at);
    exp_t e;
    e.kind = k;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic monitor();
    logic echo_p;
    logic busy_p;
    ev_t  obs[$];
    exp_t e;
    echo_p = echo;
    busy_p = busy;
    forever begin
      @(negedge clk);
      obs.delete();
      if (busy === 1'b1 && busy_p !== 1'b1) obs.push_back(EV_BUSY_RISE);
      if (trig_err === 1'b1) obs.push_back(EV_TERR);
      if (echo === 1'b1 && echo_p !== 1'b1) obs.push_back(EV_ECHO_RISE);
      if (echo !== 1'b1 && echo_p === 1'b1) obs.push_back(EV_ECHO_FALL);
      if (done === 1'b1) obs.push_back(EV_DONE);
      if (busy !== 1'b1 && busy_p === 1'b1) obs.push_back(EV_BUSY_FALL);
      echo_p = echo;
      busy_p = busy;
      foreach (obs[i]) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: observed %s at cycle %0d, required no event",
                   obs[i].name(), cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind != obs[i] || e.at != cyc) begin
            failures++;
            $display("FAIL sb_event: observed %s at cycle %0d, required %s at cycle %0d",
                     obs[i].name(), cyc, e.kind.name(), e.at);
          end
        end
      end
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raw trig is high for exactly h sampling edges; k is the edge that first samples it low.
  task automatic launch(input int h, output int k);
    @(posedge clk);
    #1;
    trig = 1'b1;
    push(EV_BUSY_RISE, cyc + 3);
    repeat (h) @(posedge clk);
    #1;
    trig = 1'b0;
    k = cyc + 1;
  endtask

  task automatic push_ok(input int k, input int w);
    int rise;
    int fall;
    rise = k + 2 + BURST_US * TICK_DIV;
    fall = rise + w * TICK_DIV;
    push(EV_ECHO_RISE, rise);
    push(EV_ECHO_FALL, fall);
    push(EV_DONE, fall);
    push(EV_BUSY_FALL, fall + HOLDOFF_US * TICK_DIV);
  endtask

  task automatic push_err(input int k);
    push(EV_TERR, k + 2);
    push(EV_BUSY_FALL, k + 2);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d events pending (next %s at cycle %0d) at cycle %0d, required 0",
               sb.size(), sb[0].kind.name(), sb[0].at, cyc);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({echo, busy, done, trig_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hold: {echo,busy,done,trig_err}=%b required 0000",
               {echo, busy, done, trig_err});
    end
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({echo, busy, done, trig_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release: {echo,busy,done,trig_err}=%b required 0000",
               {echo, busy, done, trig_err});
    end
  endtask

  task automatic test_normal();
    int k;
    echo_us = 16'd7;
    launch(MIN_CYC + 5, k);
    push_ok(k, 7);
    drain(400);
    echo_us = 16'd1;
    launch(MIN_CYC, k);
    push_ok(k, 1);
    drain(400);
  endtask

  task automatic test_short_trigger();
    int k;
    echo_us = 16'd7;
    launch(MIN_CYC - 1, k);
    push_err(k);
    drain(100);
    checks++;
    if ({echo, busy} !== 2'b00) begin
      failures++;
      $display("FAIL short_idle: {echo,busy}=%b required 00", {echo, busy});
    end
    launch(1, k);
    push_err(k);
    drain(100);
  endtask

  task automatic test_timeout();
    int vals[4] = '{0, 41, 40, 65535};
    int k;
    foreach (vals[i]) begin
      echo_us = ECHO_W'(vals[i]);
      launch(MIN_CYC, k);
      push_ok(k, exp_width(vals[i]));
      drain(600);
    end
  endtask

  task automatic test_ignored_trig();
    int k;
    echo_us = 16'd7;
    launch(MIN_CYC + 2, k);
    push_ok(k, 7);
    goto(k + 4);  trig = 1'b1;
    goto(k + 9);  trig = 1'b0;
    goto(k + 25); trig = 1'b1;
    goto(k + 42); trig = 1'b0;
    goto(k + 55); trig = 1'b1;
    goto(k + 60); trig = 1'b0;
    goto(k + 70); trig = 1'b1;
    goto(k + 120); trig = 1'b0;
    drain(100);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL held_trig_no_retrigger: busy=%b required 0", busy);
    end
    launch(MIN_CYC, k);
    push_ok(k, 7);
    drain(400);
  endtask

  task automatic test_echo_us_change();
    int k;
    echo_us = 16'd7;
    launch(MIN_CYC, k);
    push_ok(k, 7);
    goto(k + 10);
    echo_us = 16'd2;
    goto(k + 30);
    echo_us = 16'd40;
    drain(400);
  endtask

  task automatic test_reset_mid_echo();
    int k;
    echo_us = 16'd10;
    launch(MIN_CYC, k);
    push(EV_ECHO_RISE, k + 2 + BURST_US * TICK_DIV);
    goto(k + 30);
    #1;
    reset_n = 1'b0;
    push(EV_ECHO_FALL, cyc);
    push(EV_BUSY_FALL, cyc);
    #1;
    checks++;
    if ({echo, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async: {echo,busy,done}=%b required 000", {echo, busy, done});
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drain(50);
  endtask

  task automatic test_enable_mid_echo();
    int k;
    echo_us = 16'd10;
    launch(MIN_CYC, k);
    push(EV_ECHO_RISE, k + 2 + BURST_US * TICK_DIV);
    goto(k + 30);
    enable = 1'b0;
    push(EV_ECHO_FALL, k + 31);
    push(EV_BUSY_FALL, k + 31);
    goto(k + 35);
    enable = 1'b1;
    drain(50);
    echo_us = 16'd3;
    launch(MIN_CYC + 1, k);
    push_ok(k, 3);
    drain(400);
  endtask

  task automatic test_back_to_back();
    int k;
    echo_us = 16'd5;
    launch(MIN_CYC + 3, k);
    push_ok(k, 5);
    drain(400);
    echo_us = 16'd12;
    launch(MIN_CYC, k);
    push_ok(k, 12);
    drain(400);
  endtask

  initial begin
    test_reset();
    fork
      monitor();
    join_none
    test_normal();
    test_short_trigger();
    test_timeout();
    test_ignored_trig();
    test_echo_us_change();
    test_reset_mid_echo();
    test_enable_mid_echo();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
